// File: rtl/delay_timer.sv
// rtl/delay_timer.sv - LEN-unit delay/interval timer with one-shot/periodic modes and abort.
// Optional freeze input enabled by DELAY_TIMER_PAUSE_EN.
module delay_timer #(
    parameter int FCLK_HZ = 5000,
    parameter int TICK_HZ = 1000,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
`ifdef DELAY_TIMER_PAUSE_EN
    input  logic             pause,
`endif
    input  logic             periodic,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             tick,
    output logic [CNT_W-1:0] remain
);

    localparam int DIV = FCLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("delay_timer: FCLK_HZ/TICK_HZ must be >= 1");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    prescaler, pre_n;
    logic [CNT_W-1:0] len_q, len_n, rem_n;
    logic             periodic_q, per_n;
    logic             busy_n, done_n, tick_n;
    logic             hold;

`ifdef DELAY_TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prescaler  <= '0;
            len_q      <= '0;
            periodic_q <= 1'b0;
            remain     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tick       <= 1'b0;
        end else begin
            state      <= state_n;
            prescaler  <= pre_n;
            len_q      <= len_n;
            periodic_q <= per_n;
            remain     <= rem_n;
            busy       <= busy_n;
            done       <= done_n;
            tick       <= tick_n;
        end
    end

    // Priority: abort, then start (restart), then normal counting.
    always_comb begin
        state_n = state;
        pre_n   = prescaler;
        rem_n   = remain;
        len_n   = len_q;
        per_n   = periodic_q;
        busy_n  = busy;
        done_n  = 1'b0;
        tick_n  = 1'b0;
        if (abort) begin
            state_n = IDLE;
            pre_n   = '0;
            rem_n   = '0;
            busy_n  = 1'b0;
        end else if (start) begin
            pre_n = '0;
            if (len != '0) begin
                state_n = RUN;
                rem_n   = len;
                len_n   = len;
                per_n   = periodic;
                busy_n  = 1'b1;
            end else begin
                state_n = IDLE;
                rem_n   = '0;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
        end else if (state == RUN && !hold) begin
            if (prescaler == PRE_LAST) begin
                pre_n  = '0;
                tick_n = 1'b1;
                if (remain <= CNT_W'(1)) begin
                    done_n = 1'b1;
                    if (periodic_q) begin
                        rem_n = len_q;
                    end else begin
                        state_n = IDLE;
                        rem_n   = '0;
                        busy_n  = 1'b0;
                    end
                end else begin
                    rem_n = remain - 1'b1;
                end
            end else begin
                pre_n = prescaler + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_delay_timer.sv
// tb/tb_delay_timer.sv - scoreboard bench for delay_timer at DIV=5.
module tb_delay_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pause = 1'b0;
    logic        periodic = 1'b0;
    logic [31:0] len = '0;
    logic        busy, done, tick;
    logic [31:0] remain;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic        tick;
        logic        done;
        logic        busy;
        logic [31:0] rem;
    } ev_t;

    ev_t q[$];

    delay_timer #(.FCLK_HZ(5000), .TICK_HZ(1000), .CNT_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
`ifdef DELAY_TIMER_PAUSE_EN
        .pause(pause),
`endif
        .periodic(periodic),
        .len(len),
        .busy(busy),
        .done(done),
        .tick(tick),
        .remain(remain)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_ev(input int c, input logic t, input logic d, input logic b, input logic [31:0] r);
        ev_t e;
        e.cyc = c; e.tick = t; e.done = d; e.busy = b; e.rem = r;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // Returns at the falling edge just before rising edge number e.
    task automatic goto_edge(input int e);
        @(negedge clk);
        while (cyc < e - 1) @(negedge clk);
    endtask

    task automatic do_start(input int e, input logic [31:0] l, input logic p);
        goto_edge(e);
        start = 1'b1; len = l; periodic = p;
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst && (tick || done)) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event cyc=%0d tick=%b done=%b busy=%b remain=%0h",
                         cyc, tick, done, busy, remain);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.tick !== tick || e.done !== done ||
                    e.busy !== busy || e.rem !== remain) begin
                    n_err++;
                    $display("FAIL event got cyc=%0d t=%b d=%b b=%b r=%0h want cyc=%0d t=%b d=%b b=%b r=%0h",
                             cyc, tick, done, busy, remain, e.cyc, e.tick, e.done, e.busy, e.rem);
                end
            end
        end
    end

    initial begin
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_tick", 32'(tick), 0);
        chk("reset_remain", remain, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // One-shot len=3
        exp_ev(15, 1, 0, 1, 2);
        exp_ev(20, 1, 0, 1, 1);
        exp_ev(25, 1, 1, 0, 0);
        do_start(10, 3, 0);
        chk("oneshot_remain_load", remain, 3);
        chk("oneshot_busy", 32'(busy), 1);

        // Periodic len=2, aborted at edge 75
        exp_ev(45, 1, 0, 1, 1);
        exp_ev(50, 1, 1, 1, 2);
        exp_ev(55, 1, 0, 1, 1);
        exp_ev(60, 1, 1, 1, 2);
        exp_ev(65, 1, 0, 1, 1);
        exp_ev(70, 1, 1, 1, 2);
        do_start(40, 2, 1);
        goto_edge(75);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_remain", remain, 0);

        // len=0
        exp_ev(90, 0, 1, 0, 0);
        do_start(90, 0, 0);
        chk("len0_busy", 32'(busy), 0);

        // Restart mid-run with len=1
        exp_ev(105, 1, 0, 1, 2);
        do_start(100, 3, 0);
        exp_ev(112, 1, 1, 0, 0);
        do_start(107, 1, 0);

        // abort and start together
        exp_ev(135, 1, 0, 1, 4);
        do_start(130, 5, 0);
        goto_edge(140);
        abort = 1'b1; start = 1'b1; len = 4;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk("abort_start_busy", 32'(busy), 0);
        chk("abort_start_remain", remain, 0);

        // Maximum length
        exp_ev(155, 1, 0, 1, 32'hFFFF_FFFE);
        do_start(150, 32'hFFFF_FFFF, 0);
        chk("maxlen_remain", remain, 32'hFFFF_FFFF);
        goto_edge(158);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("maxlen_abort_busy", 32'(busy), 0);

`ifdef DELAY_TIMER_PAUSE_EN
        exp_ev(183, 1, 0, 1, 1);
        exp_ev(188, 1, 1, 0, 0);
        do_start(170, 2, 0);
        goto_edge(173);
        pause = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("pause_remain", remain, 2);
            chk("pause_busy", 32'(busy), 1);
        end
        pause = 1'b0;
`endif

        // Asynchronous reset mid-run
        do_start(200, 3, 0);
        goto_edge(203);
        #2 rst = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_remain", remain, 0);
        chk("async_done", 32'(done), 0);
        chk("async_tick", 32'(tick), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);

        chk("queue_empty", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
